// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin owner of the byte FIFO push port.
// Picks one of NUM_REQ producers, then walks the FIFO's fixed
// push / write / advance handshake while holding the word on fifo_data.
module fifo_push_arbiter #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REQ    = 4,
    parameter  int CNT_WIDTH  = 16,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          fifo_push,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    input  logic                          fifo_full,
    input  logic                          fifo_busy,
    output logic [ID_W-1:0]               grant_id,
    output logic                          active,
    output logic [CNT_WIDTH-1:0]          push_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WRITE, ADVANCE} state_t;

    state_t                             state, state_nxt;
    logic [ID_W-1:0]                    ptr, ptr_nxt, win_id, cand;
    logic                               win_found, grant;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_word;
    int                                 idx;

    // Same bit layout as the flat bus: word i sits at [i*DATA_WIDTH +: DATA_WIDTH].
    assign req_word = req_data;

    // Rotating priority search: scan downwards so the lowest offset from ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_W'(idx);
            if (req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
        if (int'(win_id) == NUM_REQ - 1) ptr_nxt = '0;
        else                             ptr_nxt = win_id + ID_W'(1);
    end

    // Full/busy are only honoured in IDLE; nobody else can push, so full
    // cannot newly rise once the handshake has started.
    assign grant = (state == IDLE) && win_found && !fifo_full && !fifo_busy;

    // Next-state: the handshake is a fixed walk once a grant is taken.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = WRITE;
            WRITE:   state_nxt = ADVANCE;
            ADVANCE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; active is registered from the next state so it lines up with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            active <= (state_nxt != IDLE);
        end
    end

    // Grant-edge outputs: ack/push pulse for one cycle, data held until the next grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr        <= '0;
            ack        <= '0;
            fifo_push  <= 1'b0;
            fifo_data  <= '0;
            grant_id   <= '0;
            push_count <= '0;
        end else begin
            ack       <= '0;
            fifo_push <= 1'b0;
            if (grant) begin
                ack        <= NUM_REQ'(1) << win_id;
                fifo_push  <= 1'b1;
                fifo_data  <= req_word[win_id];
                grant_id   <= win_id;
                ptr        <= ptr_nxt;
                push_count <= push_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
